// File: rtl/sam_mouse.sv
// sam_mouse: PS/2 mouse packets -> SAM Coupe nibble-sequence mouse on port 0xFFFE.
// Build option: define SAM_MOUSE_PARITY_EN to drop frames with bad odd parity.
module sam_mouse #(
    parameter int CLK_MHZ        = 96,
    parameter int RD_TIMEOUT_US  = 50,
    parameter int BIT_TIMEOUT_US = 200
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [15:0] addr,
    input  logic        io_rd,
    output logic        sel,
    output logic [3:0]  nibble,
    output logic        present
);
    localparam int RD_LIMIT  = RD_TIMEOUT_US * CLK_MHZ;
    localparam int BIT_LIMIT = BIT_TIMEOUT_US * CLK_MHZ;
    localparam int RD_W      = $clog2(RD_LIMIT + 1);
    localparam int BIT_W     = $clog2(BIT_LIMIT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [1:0]       clk_sync_reg, data_sync_reg;
    logic             clk_prev_reg;
    logic             fall, bit_in;
    rx_state_t        state_reg, state_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic [BIT_W-1:0] bit_timer_reg;
    logic             byte_valid, rx_abort, timeout;
`ifdef SAM_MOUSE_PARITY_EN
    logic             parity_reg, parity_next;
    logic             parity_ok;
`endif

    logic [1:0]       pkt_cnt_reg;
    logic [6:0]       hdr_reg;      // {y_ovf, x_ovf, y_sign, x_sign, M, R, L}
    logic [7:0]       byte1_reg;
    logic             pkt_done;
    logic [8:0]       dx, dy;
    logic [11:0]      acc_x_reg, acc_y_reg, snap_x_reg, snap_y_reg;
    logic [11:0]      acc_x_base, acc_y_base, acc_x_next, acc_y_next;
    logic [2:0]       btn_reg;
    logic             present_reg;
    logic [2:0]       idx_reg;
    logic [RD_W-1:0]  rd_timer_reg;
    logic             rd_act, rd_prev_reg, rd_end, seq_start;

    function automatic logic [8:0] delta(input logic sign, input logic ovf, input logic [7:0] mag);
        if (ovf)
            return sign ? 9'h100 : 9'h0FF;
        return {sign, mag};
    endfunction

    function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [8:0] d);
        logic [12:0] s;
        s = {a[11], a} + {{4{d[8]}}, d};
        if (s[12] != s[11])
            return s[12] ? 12'h800 : 12'h7FF;
        return s[11:0];
    endfunction

    // Line synchronizers; idle level of both PS/2 lines is high
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            clk_prev_reg  <= clk_sync_reg[1];
        end
    end

    assign fall    = clk_prev_reg & ~clk_sync_reg[1];
    assign bit_in  = data_sync_reg[1];
    assign timeout = (state_reg != RX_IDLE) && (bit_timer_reg == BIT_W'(BIT_LIMIT));
`ifdef SAM_MOUSE_PARITY_EN
    assign parity_ok = ^{shift_reg, parity_reg};
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg     <= RX_IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            bit_timer_reg <= '0;
`ifdef SAM_MOUSE_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
`ifdef SAM_MOUSE_PARITY_EN
            parity_reg  <= parity_next;
`endif
            if (state_reg == RX_IDLE || fall)
                bit_timer_reg <= '0;
            else if (bit_timer_reg != BIT_W'(BIT_LIMIT))
                bit_timer_reg <= bit_timer_reg + 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        byte_valid   = 1'b0;
        rx_abort     = 1'b0;
`ifdef SAM_MOUSE_PARITY_EN
        parity_next  = parity_reg;
`endif
        if (timeout) begin
            state_next = RX_IDLE;
            rx_abort   = 1'b1;
        end else if (fall) begin
            case (state_reg)
                RX_IDLE: begin
                    if (!bit_in) begin
                        state_next   = RX_DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_next   = {bit_in, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = RX_PARITY;
                end
                RX_PARITY: begin
`ifdef SAM_MOUSE_PARITY_EN
                    parity_next = bit_in;
`endif
                    state_next  = RX_STOP;
                end
                default: begin
                    state_next = RX_IDLE;
                    if (bit_in) begin
`ifdef SAM_MOUSE_PARITY_EN
                        if (parity_ok)
                            byte_valid = 1'b1;
                        else
                            rx_abort = 1'b1;
`else
                        byte_valid = 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    // Byte2 is still in shift_reg on the cycle it completes
    assign pkt_done = byte_valid && (pkt_cnt_reg == 2'd2);
    assign dx       = delta(hdr_reg[3], hdr_reg[5], byte1_reg);
    assign dy       = delta(hdr_reg[4], hdr_reg[6], shift_reg);

    assign sel       = (addr == 16'hFFFE);
    assign rd_act    = io_rd & sel;
    assign rd_end    = rd_prev_reg & ~rd_act;
    assign seq_start = rd_end && (idx_reg == 3'd0);

    always_comb begin
        acc_x_base = seq_start ? 12'd0 : acc_x_reg;
        acc_y_base = seq_start ? 12'd0 : acc_y_reg;
        acc_x_next = pkt_done ? sat_add(acc_x_base, dx) : acc_x_base;
        acc_y_next = pkt_done ? sat_add(acc_y_base, dy) : acc_y_base;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pkt_cnt_reg  <= 2'd0;
            hdr_reg      <= 7'd0;
            byte1_reg    <= 8'd0;
            acc_x_reg    <= 12'd0;
            acc_y_reg    <= 12'd0;
            snap_x_reg   <= 12'd0;
            snap_y_reg   <= 12'd0;
            btn_reg      <= 3'd0;
            present_reg  <= 1'b0;
            idx_reg      <= 3'd0;
            rd_timer_reg <= '0;
            rd_prev_reg  <= 1'b0;
        end else begin
            if (rx_abort) begin
                pkt_cnt_reg <= 2'd0;
            end else if (byte_valid) begin
                case (pkt_cnt_reg)
                    2'd0: begin
                        if (shift_reg[3]) begin
                            hdr_reg     <= {shift_reg[7:4], shift_reg[2:0]};
                            pkt_cnt_reg <= 2'd1;
                        end
                    end
                    2'd1: begin
                        byte1_reg   <= shift_reg;
                        pkt_cnt_reg <= 2'd2;
                    end
                    default: pkt_cnt_reg <= 2'd0;
                endcase
            end

            acc_x_reg <= acc_x_next;
            acc_y_reg <= acc_y_next;
            if (pkt_done) begin
                btn_reg     <= hdr_reg[2:0];
                present_reg <= 1'b1;
            end
            if (seq_start) begin
                snap_x_reg <= acc_x_reg;
                snap_y_reg <= acc_y_reg;
            end

            // Timer is held clear during a read so the nibble cannot change mid-read
            rd_prev_reg <= rd_act;
            if (rd_end) begin
                idx_reg      <= idx_reg + 3'd1;
                rd_timer_reg <= '0;
            end else if (rd_act) begin
                rd_timer_reg <= '0;
            end else if (rd_timer_reg != RD_W'(RD_LIMIT)) begin
                rd_timer_reg <= rd_timer_reg + 1'b1;
            end else if (idx_reg != 3'd0) begin
                idx_reg <= 3'd0;
            end
        end
    end

    always_comb begin
        nibble = 4'hF;
        case (idx_reg)
            3'd1:    nibble = {1'b1, ~btn_reg};
            3'd2:    nibble = snap_y_reg[11:8];
            3'd3:    nibble = snap_y_reg[7:4];
            3'd4:    nibble = snap_y_reg[3:0];
            3'd5:    nibble = snap_x_reg[11:8];
            3'd6:    nibble = snap_x_reg[7:4];
            3'd7:    nibble = snap_x_reg[3:0];
            default: nibble = 4'hF;
        endcase
    end

    assign present = present_reg;
endmodule

// File: tb/tb_sam_mouse.sv
// tb_sam_mouse: drives PS/2 packets and CPU reads; a behavioural mouse model feeds an expected-nibble queue.
module tb_sam_mouse;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic        io_rd = 1'b0;
    logic        sel;
    logic [3:0]  nibble;
    logic        present;

    always #5 clk_sys = ~clk_sys;

    // One clock per microsecond keeps PS/2 frames and timeouts short
    sam_mouse #(.CLK_MHZ(1), .RD_TIMEOUT_US(50), .BIT_TIMEOUT_US(200)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .addr(addr), .io_rd(io_rd), .sel(sel), .nibble(nibble), .present(present)
    );

    int         n_vec = 0;
    int         n_miss = 0;
    logic [3:0] exp_q[$];

    int         m_idx, m_acc_x, m_acc_y, m_snap_x, m_snap_y;
    logic [2:0] m_btn;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int mdelta(input logic sign, input logic ovf, input logic [7:0] mag);
        if (ovf) return sign ? -256 : 255;
        return sign ? int'(mag) - 256 : int'(mag);
    endfunction

    function automatic logic [3:0] exp_nibble();
        logic [11:0] x, y;
        x = m_snap_x[11:0];
        y = m_snap_y[11:0];
        case (m_idx)
            1: return {1'b1, ~m_btn};
            2: return y[11:8];
            3: return y[7:4];
            4: return y[3:0];
            5: return x[11:8];
            6: return x[7:4];
            7: return x[3:0];
            default: return 4'hF;
        endcase
    endfunction

    task automatic model_reset();
        m_idx = 0; m_acc_x = 0; m_acc_y = 0; m_snap_x = 0; m_snap_y = 0; m_btn = 3'b000;
    endtask

    task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        m_acc_x = clamp(m_acc_x + mdelta(b0[4], b0[6], b1));
        m_acc_y = clamp(m_acc_y + mdelta(b0[5], b0[7], b2));
        m_btn   = b0[2:0];
    endtask

    // nbits < 11 sends only the leading part of the frame
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] fr;
        logic        p;
        p = ~^b;
        if (bad_par) p = ~p;
        fr = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            tick(6);
            ps2_clk = 1'b0;
            tick(6);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(20);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0, 11);
        send_frame(b1, 1'b0, 11);
        send_frame(b2, 1'b0, 11);
        model_packet(b0, b1, b2);
        $display("packet %h %h %h -> model X=%0d Y=%0d", b0, b1, b2, m_acc_x, m_acc_y);
    endtask

    task automatic do_read(input logic [15:0] a);
        logic       hit;
        logic [3:0] e;
        hit = (a == 16'hFFFE);
        @(negedge clk_sys);
        addr  = a;
        io_rd = 1'b1;
        if (hit) exp_q.push_back(exp_nibble());
        tick(2);
        check("sel", {15'd0, sel}, {15'd0, hit});
        if (hit) begin
            e = exp_q.pop_front();
            check($sformatf("nibble_idx%0d", m_idx), {12'd0, nibble}, {12'd0, e});
            $display("read %h idx=%0d nibble=%h expect=%h", a, m_idx, nibble, e);
        end else begin
            $display("read %h sel=%0d", a, sel);
        end
        io_rd = 1'b0;
        tick(2);
        if (hit) begin
            if (m_idx == 0) begin
                m_snap_x = m_acc_x; m_snap_y = m_acc_y;
                m_acc_x = 0; m_acc_y = 0;
            end
            m_idx = (m_idx + 1) % 8;
        end
    endtask

    task automatic read_seq();
        for (int i = 0; i < 8; i++) do_read(16'hFFFE);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(2);
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick(1);
        pulse_reset();
        check("present_after_reset", {15'd0, present}, 16'd0);
        read_seq();

        send_packet(8'h09, 8'h10, 8'h20);
        check("present_after_packet", {15'd0, present}, 16'd1);
        read_seq();

        send_packet(8'h38, 8'hF0, 8'hFF);
        read_seq();
        read_seq();

        // Read timeout and foreign-address reads
        for (int i = 0; i < 3; i++) do_read(16'hFFFE);
        tick(60);
        m_idx = 0;
        do_read(16'hFFFE);
        do_read(16'h00FE);
        for (int i = 0; i < 7; i++) do_read(16'hFFFE);

        for (int i = 0; i < 20; i++) send_packet(8'h08, 8'h7F, 8'h00);
        read_seq();

        // Overflow flags: X forced to -256, Y forced to +255
        send_packet(8'hD8, 8'h12, 8'h34);
        read_seq();

        // Corrupted parity on byte1
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h05, 1'b1, 11);
        send_frame(8'h03, 1'b0, 11);
`ifndef SAM_MOUSE_PARITY_EN
        model_packet(8'h08, 8'h05, 8'h03);
`endif
        send_packet(8'h0B, 8'h04, 8'hFC);
        read_seq();

        // Reset in the middle of a packet and a frame
        send_frame(8'h09, 1'b0, 11);
        send_frame(8'h55, 1'b0, 5);
        pulse_reset();
        check("present_after_midframe_reset", {15'd0, present}, 16'd0);
        send_packet(8'h0C, 8'h02, 8'h01);
        check("present_after_recovery", {15'd0, present}, 16'd1);
        read_seq();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
